// File: rtl/tb_sys_ctrl.sv
// tb_sys_ctrl: simulation system controller for ORPSoC benches.
//   Staggers NRST per-domain synchronous resets after the master reset.
//   Snoops Wishbone for a software exit write and runs a RUN-cycle watchdog.
//   Optional macro TB_SYS_CTRL_WDKICK_EN: an acked write to KICK_ADR clears the watchdog.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high master reset
//   rst_o[NRST]               per-domain active-high resets
//   wb_adr/dat/we/cyc/stb/ack snooped bus
//   done_o, pass_o, timeout_o run status (sticky until reset)
//   exit_code_o               data of the exit write
//   cycle_cnt_o               saturating count of RUN cycles
module tb_sys_ctrl #(
  parameter int unsigned       NRST        = 2,
  parameter int unsigned       RST_HOLD    = 10,
  parameter int unsigned       RST_STAGGER = 4,
  parameter int unsigned       AW          = 32,
  parameter int unsigned       DW          = 32,
  parameter logic [AW-1:0]     EXIT_ADR    = AW'(32'h9000_0000),
  parameter logic [AW-1:0]     KICK_ADR    = AW'(32'h9000_0004),
  parameter int unsigned       TIMEOUT     = 0,
  parameter int unsigned       CW          = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  output logic [NRST-1:0] rst_o,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_ack_i,
  output logic            done_o,
  output logic            pass_o,
  output logic            timeout_o,
  output logic [DW-1:0]   exit_code_o,
  output logic [CW-1:0]   cycle_cnt_o
);

  typedef enum logic [2:0] {S_RESET, S_RELEASE, S_RUN, S_DONE, S_TMO} state_t;

  // rel_cnt value at which the last domain is released
  localparam logic [31:0] T_LAST = 32'(RST_HOLD - 1 + (NRST - 1) * RST_STAGGER);

  state_t      state, state_nxt;
  logic [31:0] rel_cnt, rel_nxt;
  logic [31:0] wd_cnt;
  logic        wb_write, exit_hit, kick_match, kick, wd_expire;

  assign wb_write   = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_i;
  assign exit_hit   = wb_write && (wb_adr_i[AW-1:2] == EXIT_ADR[AW-1:2]);
  assign kick_match = wb_write && (wb_adr_i[AW-1:2] == KICK_ADR[AW-1:2]);
  assign wd_expire  = (TIMEOUT != 0) && (wd_cnt == 32'(TIMEOUT - 1));

`ifdef TB_SYS_CTRL_WDKICK_EN
  assign kick = kick_match;
  logic unused_bits;
  assign unused_bits = ^wb_adr_i[1:0];
`else
  assign kick = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], kick_match};
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_RESET;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rel_nxt   = rel_cnt;
    if (wb_rst_i) begin
      state_nxt = S_RESET;
      rel_nxt   = '0;
    end else begin
      case (state)
        S_RESET: begin
          rel_nxt   = '0;
          state_nxt = (T_LAST == 32'd0) ? S_RUN : S_RELEASE;
        end
        S_RELEASE: begin
          rel_nxt = rel_cnt + 32'd1;
          if (rel_nxt >= T_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (exit_hit)                state_nxt = S_DONE;
          else if (wd_expire && !kick) state_nxt = S_TMO;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rst_o       <= '1;
      rel_cnt     <= '0;
      wd_cnt      <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      exit_code_o <= '0;
      cycle_cnt_o <= '0;
    end else begin
      rel_cnt <= rel_nxt;
      // Domain k drops once the upcoming release count reaches its threshold,
      // so it is low exactly RST_HOLD+k*RST_STAGGER cycles after reset falls.
      if (state == S_RESET || state == S_RELEASE) begin
        for (int unsigned k = 0; k < NRST; k++)
          rst_o[k] <= (rel_nxt < 32'(RST_HOLD - 1 + k * RST_STAGGER));
      end
      if (state == S_RUN) begin
        if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
        wd_cnt <= kick ? '0 : wd_cnt + 32'd1;
        // Exit hit takes priority over expiry; a kick suppresses expiry.
        if (exit_hit) begin
          exit_code_o <= wb_dat_i;
          pass_o      <= (wb_dat_i == '0);
          done_o      <= 1'b1;
        end else if (wd_expire && !kick) begin
          timeout_o <= 1'b1;
          done_o    <= 1'b1;
          pass_o    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tb_sys_ctrl.sv
module tb_tb_sys_ctrl;

  localparam int A_N = 3, A_H = 10, A_S = 4, A_TO = 100;
  localparam int B_N = 2, B_H = 2,  B_S = 1, B_TO = 50, B_CW = 4;
  localparam int A_REL = A_H + (A_N - 1) * A_S;   // 18
  localparam int B_REL = B_H + (B_N - 1) * B_S;   // 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [31:0] adr, dat;
  logic        we, cyc, stb, ack;

  logic [A_N-1:0]  rsto_a;
  logic            done_a, pass_a, tmo_a;
  logic [31:0]     code_a, cnt_a;
  logic [B_N-1:0]  rsto_b;
  logic            done_b, pass_b, tmo_b;
  logic [31:0]     code_b;
  logic [B_CW-1:0] cnt_b;

  tb_sys_ctrl #(.NRST(A_N), .RST_HOLD(A_H), .RST_STAGGER(A_S), .AW(32), .DW(32),
                .EXIT_ADR(32'h9000_0000), .KICK_ADR(32'h9000_0004),
                .TIMEOUT(A_TO), .CW(32)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .rst_o(rsto_a),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_ack_i(ack), .done_o(done_a), .pass_o(pass_a),
    .timeout_o(tmo_a), .exit_code_o(code_a), .cycle_cnt_o(cnt_a));

  tb_sys_ctrl #(.NRST(B_N), .RST_HOLD(B_H), .RST_STAGGER(B_S), .AW(32), .DW(32),
                .EXIT_ADR(32'h9000_0000), .KICK_ADR(32'h9000_0004),
                .TIMEOUT(B_TO), .CW(B_CW)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .rst_o(rsto_b),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_ack_i(ack), .done_o(done_b), .pass_o(pass_b),
    .timeout_o(tmo_b), .exit_code_o(code_b), .cycle_cnt_o(cnt_b));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] adr, dat;
    logic        we, cyc, stb, ack;
    int          idle;
    logic        e_done, e_pass;
    logic [31:0] e_code;
    int          e_cnt, e_cnt3;
  } vec_t;
  vec_t vt[8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic c, input logic s, input logic k);
    adr = a; dat = d; we = w; cyc = c; stb = s; ack = k;
    tick();
    adr = '0; dat = '0; we = 0; cyc = 0; stb = 0; ack = 0;
  endtask

  task automatic release_a();
    rst_a = 1; tick(); tick(); rst_a = 0;
    repeat (A_REL) tick();
  endtask

  task automatic release_b();
    rst_b = 1; tick(); tick(); rst_b = 0;
    repeat (B_REL) tick();
  endtask

  initial begin
    logic [A_N-1:0] e;
    int seen_at;
    int exp_to;

    vt[0] = '{32'h9000_0000, 32'h0,         1,1,1,1, 5, 1,1, 32'h0,         6, 6};
    vt[1] = '{32'h9000_0002, 32'h2A,        1,1,1,1, 3, 1,0, 32'h2A,        4, 4};
    vt[2] = '{32'h9000_0002, 32'h2A,        1,1,1,0, 3, 0,0, 32'h0,         4, 7};
    vt[3] = '{32'h9000_0004, 32'h0,         1,1,1,1, 0, 0,0, 32'h0,         1, 4};
    vt[4] = '{32'h9000_0003, 32'hFFFF_FFFF, 1,1,1,1, 7, 1,0, 32'hFFFF_FFFF, 8, 8};
    vt[5] = '{32'h9000_0000, 32'h0,         0,1,1,1, 2, 0,0, 32'h0,         3, 6};
    vt[6] = '{32'h9000_0000, 32'h0,         1,0,1,1, 2, 0,0, 32'h0,         3, 6};
    vt[7] = '{32'h8000_0000, 32'h0,         1,1,1,1, 1, 0,0, 32'h0,         2, 5};

    adr = '0; dat = '0; we = 0; cyc = 0; stb = 0; ack = 0;
    rst_a = 1; rst_b = 1;
    tick(); tick();

    // Reset state
    chk("rst_rsto", 64'(rsto_a), 64'h7);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_pass", 64'(pass_a), 0);
    chk("rst_tmo",  64'(tmo_a),  0);
    chk("rst_code", 64'(code_a), 0);
    chk("rst_cnt",  64'(cnt_a),  0);

    // Staggered release: domains low at cycles 10/14/18, RUN from cycle 18
    rst_a = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      for (int k = 0; k < A_N; k++) e[k] = (c < A_H + k * A_S);
      chk($sformatf("rel_rsto_c%0d", c), 64'(rsto_a), 64'(e));
      chk($sformatf("rel_cnt_c%0d", c), 64'(cnt_a), 64'((c >= A_REL) ? c - A_REL : 0));
    end

    // Exit write during RELEASE is ignored
    rst_a = 1; tick(); rst_a = 0;
    repeat (5) tick();
    bus_wr(32'h9000_0000, 32'h77, 1, 1, 1, 1);
    repeat (A_REL - 6) tick();
    chk("rel_ign_done", 64'(done_a), 0);
    chk("rel_ign_code", 64'(code_a), 0);
    chk("rel_ign_cnt",  64'(cnt_a),  0);

    // Table of bus patterns in RUN
    foreach (vt[i]) begin
      release_a();
      repeat (vt[i].idle) tick();
      bus_wr(vt[i].adr, vt[i].dat, vt[i].we, vt[i].cyc, vt[i].stb, vt[i].ack);
      chk($sformatf("v%0d_done", i), 64'(done_a), 64'(vt[i].e_done));
      chk($sformatf("v%0d_pass", i), 64'(pass_a), 64'(vt[i].e_pass));
      chk($sformatf("v%0d_code", i), 64'(code_a), 64'(vt[i].e_code));
      chk($sformatf("v%0d_tmo", i),  64'(tmo_a),  0);
      chk($sformatf("v%0d_cnt", i),  64'(cnt_a),  64'(vt[i].e_cnt));
      repeat (3) tick();
      chk($sformatf("v%0d_cnt3", i), 64'(cnt_a),  64'(vt[i].e_cnt3));
      if (vt[i].e_done) begin
        bus_wr(32'h9000_0000, 32'h55, 1, 1, 1, 1);
        chk($sformatf("v%0d_frz_code", i), 64'(code_a), 64'(vt[i].e_code));
        chk($sformatf("v%0d_frz_pass", i), 64'(pass_a), 64'(vt[i].e_pass));
      end
    end

    // Watchdog expiry exactly 100 RUN cycles after entry
    release_a();
    repeat (A_TO - 1) tick();
    chk("wd_pre_tmo", 64'(tmo_a), 0);
    tick();
    chk("wd_tmo",  64'(tmo_a),  1);
    chk("wd_done", 64'(done_a), 1);
    chk("wd_pass", 64'(pass_a), 0);
    chk("wd_cnt",  64'(cnt_a),  64'(A_TO));
    repeat (3) tick();
    chk("wd_cnt_frz", 64'(cnt_a), 64'(A_TO));

    // Reset out of TMO clears everything on the next edge
    rst_a = 1; tick();
    chk("tmo_rst_rsto", 64'(rsto_a), 64'h7);
    chk("tmo_rst_tmo",  64'(tmo_a),  0);
    chk("tmo_rst_done", 64'(done_a), 0);
    chk("tmo_rst_cnt",  64'(cnt_a),  0);
    rst_a = 0;

    // Exit hit on the expiry edge wins
    release_a();
    repeat (A_TO - 1) tick();
    bus_wr(32'h9000_0000, 32'h0, 1, 1, 1, 1);
    chk("race_done", 64'(done_a), 1);
    chk("race_pass", 64'(pass_a), 1);
    chk("race_tmo",  64'(tmo_a),  0);
    chk("race_cnt",  64'(cnt_a),  64'(A_TO));
    rst_a = 1;

    // Saturating counter on the CW=4 instance
    release_b();
    repeat (20) tick();
    chk("sat_cnt", 64'(cnt_b), 15);
    bus_wr(32'h9000_0000, 32'h3, 1, 1, 1, 1);
    chk("sat_done", 64'(done_b), 1);
    chk("sat_code", 64'(code_b), 3);

    // Reset pulse in DONE, then the release repeats
    rst_b = 1; tick();
    chk("b_rst_rsto", 64'(rsto_b), 64'h3);
    chk("b_rst_done", 64'(done_b), 0);
    chk("b_rst_code", 64'(code_b), 0);
    chk("b_rst_cnt",  64'(cnt_b),  0);
    rst_b = 0;
    tick();
    chk("b_rel_c1", 64'(rsto_b), 64'h3);
    tick();
    chk("b_rel_c2", 64'(rsto_b), 64'h2);
    tick();
    chk("b_rel_c3", 64'(rsto_b), 64'h0);
    chk("b_rel_cnt", 64'(cnt_b), 0);

    // Watchdog kick during RUN cycle 39 (edge ending it)
    repeat (39) tick();
    bus_wr(32'h9000_0004, 32'h0, 1, 1, 1, 1);
    seen_at = 0;
    for (int c = 40; c <= 130; c++) begin
      if (tmo_b && seen_at == 0) seen_at = c;
      tick();
    end
`ifdef TB_SYS_CTRL_WDKICK_EN
    exp_to = 90;
`else
    exp_to = 50;
`endif
    chk("kick_tmo_cycle", 64'(seen_at), 64'(exp_to));
    chk("kick_done", 64'(done_b), 1);
    chk("kick_pass", 64'(pass_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
